mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0; 0 = round-robin between ports, 1 = port 0 always wins.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mN_req  input  1  port N (N=0,1) access request; held with command fields stable until mN_gnt.
REQ-005 mN_load / mN_store  input  1 each  access type; exactly one SHALL be high while mN_req.
REQ-006 mN_funct3  input  3  RISC-V load/store funct3 (f3Ld/f3St encodings).
REQ-007 mN_addr  input  32  byte address.
REQ-008 mN_wdata  input  32  store data, right-aligned.
REQ-009 mN_gnt  output  1  combinational; command accepted this cycle.
REQ-010 mN_rvalid  output  1  registered; response valid, one-cycle pulse.
REQ-011 mN_rdata  output  32  registered load data; valid only with mN_rvalid.
REQ-012 mN_err  output  1  registered; response is an error, valid only with mN_rvalid.
REQ-013 ram_funct3 / ram_load / ram_store / ram_addr / ram_wdata  output  3/1/1/32/32  drive single-port RAM.
REQ-014 ram_rdata  input  32  combinational RAM read data; RAM writes on rising edge when ram_store.

Function
REQ-015 At most one of m0_gnt, m1_gnt SHALL be high in any cycle; a grant is issued in the same cycle as a qualifying req (zero-cycle arbitration).
REQ-016 Only one requester: that port is granted.
REQ-017 Both requesters, FIXED_PRIO=0: grant the port not granted most recently (last_gnt register, updated on every grant).
REQ-018 Both requesters, FIXED_PRIO=1: port 0 granted; port 1 waits.
REQ-019 Granted legal command: ram_* mirror the winner's funct3/load/store/addr/wdata that cycle; the store commits at the clock edge ending that cycle.
REQ-020 Granted load: ram_rdata captured at that edge into mN_rdata; mN_rvalid=1, mN_err=0 the next cycle (latency 1).
REQ-021 Granted store: mN_rvalid=1, mN_err=0, mN_rdata=0 the next cycle.
REQ-022 Illegal command (load==store, unsupported funct3, LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0): still granted, ram_load=ram_store=0, no RAM write; next cycle mN_rvalid=1, mN_err=1, mN_rdata=0.
REQ-023 No grant this cycle: ram_load=ram_store=0, ram_funct3=0, ram_addr=0, ram_wdata=0.
REQ-024 mN_rvalid SHALL deassert the cycle after its pulse unless port N is granted again; back-to-back grants to one port yield back-to-back rvalid pulses.
REQ-025 Illegal commands participate in round-robin and update last_gnt like legal ones.
REQ-026 Unrequested port never sees rvalid.

Reset
REQ-027 While rst is high: mN_rvalid=0, mN_err=0, mN_rdata=0, last_gnt=1 (port 0 wins first contested cycle); gnt outputs forced 0, ram_load/ram_store forced 0.
REQ-028 Reset asserted during a pending response SHALL drop that response; no rvalid after reset release.

Structure
REQ-029 Grant-owner typedef (OWN_M0, OWN_M1) SHALL live in the shared def.svh package set; funct3 constants reuse existing f3Ld/f3St.
REQ-030 One combinational sub-module, access_chk, instantiated per port, produces the illegal flag from load, store, funct3, addr[1:0].
REQ-031 Sequential state limited to last_gnt and per-port rvalid/err/rdata registers.

Verification
REQ-032 m0 SW addr 0x10 data 0xDEADBEEF, then m1 LW 0x10 -> m1_rvalid next cycle, m1_rdata=0xDEADBEEF, err=0.
REQ-033 Both req every cycle for 4 cycles, FIXED_PRIO=0, after reset -> grants m0,m1,m0,m1; FIXED_PRIO=1 -> m0 x4, m1 never.
REQ-034 m0 SB 0x13 data 0x000000AB over word 0 -> m1 LBU 0x13 returns 0x000000AB, LB 0x13 returns 0xFFFFFFAB.
REQ-035 m1 LW addr 0x22 -> gnt, ram_load=0, next cycle m1_rvalid=1, m1_err=1, rdata=0; m0 SH 0x21 -> err=1, memory unchanged.
REQ-036 m0 LW granted, rst pulsed before following edge -> m0_rvalid stays 0; first contested request after release grants m0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types for the two-port memory arbiter: grant-owner encoding and
// the RISC-V load/store funct3 encodings (f3Ld / f3St).
package mem_arbiter_pkg;

    typedef enum logic [0:0] {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } f3Ld;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } f3St;

endpackage

// File: rtl/mem_arbiter_access_chk.sv
// access_chk
// Combinational legality check for one port's command.
// Ports:
//   load, store  : access type (exactly one must be set)
//   funct3       : RISC-V load/store width encoding
//   addr_lo      : byte address bits [1:0]
//   illegal      : high when the command must not reach the RAM
module access_chk
    import mem_arbiter_pkg::*;
(
    input  logic       load,
    input  logic       store,
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output logic       illegal
);

    always_comb begin
        illegal = 1'b1;
        if (load && !store) begin
            case (funct3)
                F3_LB, F3_LBU: illegal = 1'b0;
                F3_LH, F3_LHU: illegal = addr_lo[0];
                F3_LW:         illegal = |addr_lo;
                default:       illegal = 1'b1;
            endcase
        end else if (store && !load) begin
            case (funct3)
                F3_SB:   illegal = 1'b0;
                F3_SH:   illegal = addr_lo[0];
                F3_SW:   illegal = |addr_lo;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port arbiter in front of a single-port RAM. Grants are issued in the
// same cycle as the request; responses (rvalid/err/rdata) follow one cycle
// later as registered pulses.
// Parameters:
//   FIXED_PRIO : 0 = round-robin on contention, 1 = port 0 always wins
// Ports:
//   clk, rst                 : clock, async active-high reset
//   mN_req/load/store        : port N request and access type
//   mN_funct3/addr/wdata     : port N command fields
//   mN_gnt                   : combinational grant
//   mN_rvalid/err/rdata      : registered response
//   ram_funct3/load/store/addr/wdata : RAM command (zero when idle)
//   ram_rdata                : combinational RAM read data
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_load,
    input  logic        m0_store,
    input  logic [2:0]  m0_funct3,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_load,
    input  logic        m1_store,
    input  logic [2:0]  m1_funct3,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic [2:0]  ram_funct3,
    output logic        ram_load,
    output logic        ram_store,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    owner_t last_gnt;
    logic   m0_ill;
    logic   m1_ill;
    logic   m0_wins;

    access_chk u_chk_m0 (
        .load    (m0_load),
        .store   (m0_store),
        .funct3  (m0_funct3),
        .addr_lo (m0_addr[1:0]),
        .illegal (m0_ill)
    );

    access_chk u_chk_m1 (
        .load    (m1_load),
        .store   (m1_store),
        .funct3  (m1_funct3),
        .addr_lo (m1_addr[1:0]),
        .illegal (m1_ill)
    );

    // Contention tie-break: the port that did not win last time goes next.
    always_comb begin
        if (FIXED_PRIO != 0) begin
            m0_wins = 1'b1;
        end else begin
            m0_wins = (last_gnt == OWN_M1);
        end
    end

    assign m0_gnt = !rst && m0_req && (!m1_req || m0_wins);
    assign m1_gnt = !rst && m1_req && !(m0_req && m0_wins);

    // Illegal commands still drive the other fields, but never strobe the RAM.
    always_comb begin
        ram_funct3 = '0;
        ram_load   = 1'b0;
        ram_store  = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        if (m0_gnt) begin
            ram_funct3 = m0_funct3;
            ram_load   = m0_load  && !m0_ill;
            ram_store  = m0_store && !m0_ill;
            ram_addr   = m0_addr;
            ram_wdata  = m0_wdata;
        end else if (m1_gnt) begin
            ram_funct3 = m1_funct3;
            ram_load   = m1_load  && !m1_ill;
            ram_store  = m1_store && !m1_ill;
            ram_addr   = m1_addr;
            ram_wdata  = m1_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt  <= OWN_M1;
            m0_rvalid <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_rvalid <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            if (m0_gnt) begin
                last_gnt <= OWN_M0;
            end else if (m1_gnt) begin
                last_gnt <= OWN_M1;
            end
            m0_rvalid <= m0_gnt;
            m0_err    <= m0_gnt && m0_ill;
            m0_rdata  <= (m0_gnt && m0_load && !m0_ill) ? ram_rdata : '0;
            m1_rvalid <= m1_gnt;
            m1_err    <= m1_gnt && m1_ill;
            m1_rdata  <= (m1_gnt && m1_load && !m1_ill) ? ram_rdata : '0;
        end
    end

endmodule
